// File: rtl/dispatcher_rr.sv
// Two-way round-robin dispatcher: one valid/ready stream fanned out to two 2-entry lane FIFOs.
// Latency: an accepted item reaches its lane head one cycle later (more if the lane is occupied).
// Backpressure: in_ready depends on registered lane occupancy only; a stalled lane is skipped
//   unless DISPATCHER_RR_STRICT_EN is defined, in which case the input waits for the preferred lane.
//
// Ports:
//   clk, reset          - rising-edge clock, synchronous active-high reset
//   in_valid/in_data    - producer stream, in_ready = item accepted this cycle
//   out_N_valid/data    - lane N FIFO head, out_N_ready = consumer takes the head
// Parameters: DWIDTH (item width), PRIORITY_0 (1: lane 0 receives the first item after reset).
// Optional macro: DISPATCHER_RR_STRICT_EN selects strict 0,1,0,1 alternation.
module dispatcher_rr #(
    parameter int DWIDTH     = 16,
    parameter int PRIORITY_0 = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [DWIDTH-1:0] in_data,
    output logic              in_ready,
    output logic              out_0_valid,
    output logic [DWIDTH-1:0] out_0_data,
    input  logic              out_0_ready,
    output logic              out_1_valid,
    output logic [DWIDTH-1:0] out_1_data,
    input  logic              out_1_ready
);

    // Lane FIFO state
    logic [1:0]        r_cnt0, r_cnt1;
    logic              r_rd0, r_wr0, r_rd1, r_wr1;
    logic [DWIDTH-1:0] r_mem0 [2];
    logic [DWIDTH-1:0] r_mem1 [2];

    // Lane that received the most recent item
    logic r_last;

    logic w_space0, w_space1;
    logic w_pref;
    logic w_target;
    logic w_in_ready;
    logic w_acc;
    logic w_push0, w_push1, w_pop0, w_pop1;

    // Space ignores a same-cycle pop, so there is no ready-to-ready combinational path.
    assign w_space0 = (r_cnt0 != 2'd2);
    assign w_space1 = (r_cnt1 != 2'd2);
    assign w_pref   = ~r_last;

`ifdef DISPATCHER_RR_STRICT_EN
    assign w_target   = w_pref;
    assign w_in_ready = w_pref ? w_space1 : w_space0;
`else
    // Fall back to the other lane when the preferred one is full.
    assign w_target   = (w_pref ? w_space1 : w_space0) ? w_pref : ~w_pref;
    assign w_in_ready = w_space0 | w_space1;
`endif

    assign w_acc   = in_valid & w_in_ready;
    assign w_push0 = w_acc & ~w_target;
    assign w_push1 = w_acc & w_target;
    assign w_pop0  = (r_cnt0 != 2'd0) & out_0_ready;
    assign w_pop1  = (r_cnt1 != 2'd0) & out_1_ready;

    assign in_ready    = w_in_ready;
    assign out_0_valid = (r_cnt0 != 2'd0);
    assign out_1_valid = (r_cnt1 != 2'd0);
    assign out_0_data  = r_mem0[r_rd0];
    assign out_1_data  = r_mem1[r_rd1];

    always_ff @(posedge clk) begin
        if (reset) begin
            r_last <= (PRIORITY_0 == 1) ? 1'b1 : 1'b0;
        end else if (w_acc) begin
            r_last <= w_target;
        end
    end

    // Lane 0 FIFO
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt0 <= 2'd0;
            r_rd0  <= 1'b0;
            r_wr0  <= 1'b0;
            for (int i = 0; i < 2; i++) begin
                r_mem0[i] <= '0;
            end
        end else begin
            if (w_push0) begin
                r_mem0[r_wr0] <= in_data;
                r_wr0         <= ~r_wr0;
            end
            if (w_pop0) begin
                r_rd0 <= ~r_rd0;
            end
            case ({w_push0, w_pop0})
                2'b10:   r_cnt0 <= r_cnt0 + 2'd1;
                2'b01:   r_cnt0 <= r_cnt0 - 2'd1;
                default: r_cnt0 <= r_cnt0;
            endcase
        end
    end

    // Lane 1 FIFO
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt1 <= 2'd0;
            r_rd1  <= 1'b0;
            r_wr1  <= 1'b0;
            for (int i = 0; i < 2; i++) begin
                r_mem1[i] <= '0;
            end
        end else begin
            if (w_push1) begin
                r_mem1[r_wr1] <= in_data;
                r_wr1         <= ~r_wr1;
            end
            if (w_pop1) begin
                r_rd1 <= ~r_rd1;
            end
            case ({w_push1, w_pop1})
                2'b10:   r_cnt1 <= r_cnt1 + 2'd1;
                2'b01:   r_cnt1 <= r_cnt1 - 2'd1;
                default: r_cnt1 <= r_cnt1;
            endcase
        end
    end

endmodule
